// File: rtl/spawn_in_arbiter_if.sv
// Bundle of the per-accelerator spawn streams and the merged spawn_in stream.
// Valid/ready semantics on every stream: a beat transfers on a rising aclk
// edge where tvalid and tready are both 1; the sender holds payload stable
// while tvalid=1 and tready=0.
// The arbiter uses the 'slave' modport: it sinks the s_* streams and sources
// spawn_in. The 'master' modport is the environment side of the same signals.
interface spawn_in_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_ACCS  = 16
);
  localparam int TID_W = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;

  // Per-port accelerator streams, port i packed at [W*i +: W].
  logic [NUM_PORTS-1:0]    s_tvalid;
  logic [NUM_PORTS-1:0]    s_tready;
  logic [NUM_PORTS*64-1:0] s_tdata;
  logic [NUM_PORTS*5-1:0]  s_tdest;
  logic [NUM_PORTS-1:0]    s_tlast;

  // Merged stream to the manager.
  logic                    spawn_in_tvalid;
  logic                    spawn_in_tready;
  logic [TID_W-1:0]        spawn_in_tid;
  logic [4:0]              spawn_in_tdest;
  logic [63:0]             spawn_in_tdata;
  logic                    spawn_in_tlast;

  modport slave (
    input  s_tvalid, s_tdata, s_tdest, s_tlast, spawn_in_tready,
    output s_tready, spawn_in_tvalid, spawn_in_tid, spawn_in_tdest,
           spawn_in_tdata, spawn_in_tlast
  );

  modport master (
    output s_tvalid, s_tdata, s_tdest, s_tlast, spawn_in_tready,
    input  s_tready, spawn_in_tvalid, spawn_in_tid, spawn_in_tdest,
           spawn_in_tdata, spawn_in_tlast
  );
endinterface

// File: rtl/spawn_in_arbiter.sv
// Merges NUM_PORTS accelerator task-creation streams into the single spawn_in
// stream of the manager. Round-robin arbitration at packet granularity: the
// granted port owns the output until its tlast beat is accepted. Each beat is
// tagged with tid = TID_OFFSET + port. The output stage is a single register
// that can load and drain in the same cycle, so a granted packet flows at one
// beat per clock; one IDLE arbitration cycle separates consecutive packets.
module spawn_in_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_ACCS   = 16,
  parameter int TID_OFFSET = 0,
  localparam int GRANT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic               aclk,
  input  logic               ps_rst,
  spawn_in_arbiter_if.slave  bus,
  // Debug view of the arbiter: 0 = IDLE, 1 = PASS, and the current grant.
  output logic               dbg_state,
  output logic [GRANT_W-1:0] dbg_grant
);

  localparam int TID_W = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [GRANT_W-1:0]   grant, grant_n;
  logic [GRANT_W-1:0]   last_grant, last_grant_n;

  // Round-robin search result.
  logic                 rr_any;
  logic [GRANT_W-1:0]   rr_pick;
  int                   rr_idx;

  // Granted-port view of the inputs.
  logic                 sel_valid;
  logic                 sel_last;
  logic [63:0]          sel_data;
  logic [4:0]           sel_dest;

  // Handshake signals.
  logic [NUM_PORTS-1:0] s_tready_c;
  logic                 out_free;
  logic                 beat_fire;

  // Output register.
  logic                 out_valid;
  logic [TID_W-1:0]     out_tid;
  logic [4:0]           out_dest;
  logic [63:0]          out_data;
  logic                 out_last;

  // Round-robin search starting just after the last port that finished a packet.
  always_comb begin
    rr_any  = 1'b0;
    rr_pick = last_grant;
    rr_idx  = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!rr_any && bus.s_tvalid[rr_idx]) begin
        rr_any  = 1'b1;
        rr_pick = GRANT_W'(rr_idx);
      end
    end
  end

  // Select the granted port's beat.
  always_comb begin
    sel_valid = bus.s_tvalid[grant];
    sel_last  = bus.s_tlast[grant];
    sel_data  = bus.s_tdata[int'(grant)*64 +: 64];
    sel_dest  = bus.s_tdest[int'(grant)*5 +: 5];
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free  = !out_valid || bus.spawn_in_tready;
  assign beat_fire = (state == PASS) && sel_valid && out_free;

  // Only the granted port ever sees tready, and only while in PASS.
  always_comb begin
    s_tready_c = '0;
    if (state == PASS) begin
      s_tready_c[grant] = out_free;
    end
  end

  assign bus.s_tready = s_tready_c;

  // Next-state logic: arbitrate in IDLE, hold the grant through PASS until tlast.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (rr_any) begin
          grant_n = rr_pick;
          state_n = PASS;
        end
      end
      PASS: begin
        if (beat_fire && sel_last) begin
          state_n      = IDLE;
          last_grant_n = grant;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge aclk) begin
    if (ps_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GRANT_W'(NUM_PORTS - 1);
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
    end
  end

  // Output register: load on an input handshake, clear when drained, hold otherwise.
  always_ff @(posedge aclk) begin
    if (ps_rst) begin
      out_valid <= 1'b0;
      out_tid   <= '0;
      out_dest  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (beat_fire) begin
      out_valid <= 1'b1;
      out_tid   <= TID_W'(TID_OFFSET + int'(grant));
      out_dest  <= sel_dest;
      out_data  <= sel_data;
      out_last  <= sel_last;
    end else if (bus.spawn_in_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.spawn_in_tvalid = out_valid;
  assign bus.spawn_in_tid    = out_tid;
  assign bus.spawn_in_tdest  = out_dest;
  assign bus.spawn_in_tdata  = out_data;
  assign bus.spawn_in_tlast  = out_last;

  assign dbg_state = (state == PASS);
  assign dbg_grant = grant;

endmodule

// File: tb/tb_spawn_in_arbiter.sv
// Bench for spawn_in_arbiter: per-port beat sources, a merged-stream monitor
// feeding an expected-beat queue, and one task per scenario.
module tb_spawn_in_arbiter;

  localparam int NP         = 4;
  localparam int MAX_ACCS   = 16;
  localparam int TID_OFFSET = 0;
  localparam int TID_W      = 4;
  localparam int MEM_D      = 64;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_PASS  = 1'b1;

  // ---------------- clock / reset ----------------
  logic       aclk = 1'b0;
  logic       ps_rst;
  logic       sink_ready;
  logic       dbg_state;
  logic [1:0] dbg_grant;

  always #5 aclk = ~aclk;

  spawn_in_arbiter_if #(.NUM_PORTS(NP), .MAX_ACCS(MAX_ACCS)) bus ();

  spawn_in_arbiter #(
    .NUM_PORTS (NP),
    .MAX_ACCS  (MAX_ACCS),
    .TID_OFFSET(TID_OFFSET)
  ) dut (
    .aclk     (aclk),
    .ps_rst   (ps_rst),
    .bus      (bus),
    .dbg_state(dbg_state),
    .dbg_grant(dbg_grant)
  );

  assign bus.spawn_in_tready = sink_ready;

  // ---------------- scoreboard state ----------------
  logic [73:0]   exp_q[$];            // {tid, dest, data, last}
  int            log_cyc[$];          // cycle of each accepted output beat
  int            checks = 0;
  int            fails  = 0;
  int            cyc    = 0;

  logic [69:0]   src_mem [NP][MEM_D]; // {dest, data, last}
  int            src_head [NP];
  int            src_tail [NP];
  logic [NP-1:0] pause;
  logic [NP-1:0] fire_p = '0;

  function automatic logic [4:0] dest_of(input int p, input int i);
    return 5'((p * 7 + i * 3 + 1) % 32);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int p, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      src_mem[p][src_tail[p]] = {dest_of(p, i), base + 64'(i), (i == n - 1)};
      src_tail[p]++;
    end
  endtask

  task automatic expect_pkt(input int p, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({TID_W'(TID_OFFSET + p), dest_of(p, i), base + 64'(i), (i == n - 1)});
    end
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) src_tail[p] = 0;
    pause = '0;
  endtask

  task automatic apply_reset();
    @(posedge aclk); #1;
    ps_rst = 1'b1;
    @(negedge aclk);
    clear_sources();
    exp_q.delete();
    log_cyc.delete();
    repeat (3) @(posedge aclk);
    #1;
    ps_rst     = 1'b0;
    sink_ready = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge aclk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d beats pending exp 0", exp_q.size());
    end
    repeat (3) @(negedge aclk);
  endtask

  // Source driver: retire accepted beats, present the next one per port.
  always @(posedge aclk) begin
    logic [NP-1:0]    v;
    logic [NP-1:0]    l;
    logic [NP*64-1:0] d;
    logic [NP*5-1:0]  ds;
    logic [69:0]      e;
    #1;
    cyc++;
    v = '0; l = '0; d = '0; ds = '0;
    for (int p = 0; p < NP; p++) begin
      if (ps_rst) src_head[p] = 0;
      else if (fire_p[p]) src_head[p]++;
      if (src_head[p] < src_tail[p] && !pause[p]) begin
        e            = src_mem[p][src_head[p]];
        v[p]         = 1'b1;
        ds[p*5 +: 5] = e[69:65];
        d[p*64 +: 64] = e[64:1];
        l[p]         = e[0];
      end
    end
    bus.s_tvalid = v;
    bus.s_tdata  = d;
    bus.s_tdest  = ds;
    bus.s_tlast  = l;
  end

  // Monitor: capture input handshakes, score output beats.
  always @(negedge aclk) begin
    logic [73:0] got;
    logic [73:0] exp;
    fire_p = bus.s_tvalid & bus.s_tready & {NP{~ps_rst}};
    checks++;
    if (!$onehot0(bus.s_tready)) begin
      fails++;
      $display("FAIL tready_onehot got %b exp at most one bit set", bus.s_tready);
    end
    if (!ps_rst && bus.spawn_in_tvalid && bus.spawn_in_tready) begin
      got = {bus.spawn_in_tid, bus.spawn_in_tdest, bus.spawn_in_tdata, bus.spawn_in_tlast};
      log_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat got %h exp none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL beat got %h exp %h", got, exp);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge aclk);
    checks++; if (bus.spawn_in_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b exp 0", bus.spawn_in_tvalid); end
    checks++; if (bus.spawn_in_tid !== '0) begin fails++; $display("FAIL rst_tid got %h exp 0", bus.spawn_in_tid); end
    checks++; if (bus.spawn_in_tdest !== '0) begin fails++; $display("FAIL rst_tdest got %h exp 0", bus.spawn_in_tdest); end
    checks++; if (bus.spawn_in_tdata !== '0) begin fails++; $display("FAIL rst_tdata got %h exp 0", bus.spawn_in_tdata); end
    checks++; if (bus.spawn_in_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got %b exp 0", bus.spawn_in_tlast); end
    checks++; if (bus.s_tready !== '0) begin fails++; $display("FAIL rst_s_tready got %b exp 0", bus.s_tready); end
    checks++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL rst_state got %b exp %b", dbg_state, ST_IDLE); end
    checks++; if (dbg_grant !== 2'd0) begin fails++; $display("FAIL rst_grant got %0d exp 0", dbg_grant); end
  endtask

  task automatic test_single_request();
    int start;
    @(negedge aclk);
    log_cyc.delete();
    load_pkt(2, 3, 64'hA0);
    expect_pkt(2, 3, 64'hA0);
    start = cyc + 1;
    wait_drain(50);
    checks++;
    if (log_cyc.size() !== 3) begin
      fails++; $display("FAIL single_count got %0d exp 3", log_cyc.size());
    end else begin
      checks++;
      if (log_cyc[0] !== start + 2) begin fails++; $display("FAIL single_latency got %0d exp %0d", log_cyc[0], start + 2); end
      checks++;
      if (log_cyc[2] !== start + 4) begin fails++; $display("FAIL single_contig got %0d exp %0d", log_cyc[2], start + 4); end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    apply_reset();
    @(negedge aclk);
    for (int p = 0; p < NP; p++) load_pkt(p, 2, 64'h100 * (p + 1));
    for (int p = 0; p < NP; p++) expect_pkt(p, 2, 64'h100 * (p + 1));
    start = cyc + 1;
    wait_drain(80);
    checks++;
    if (log_cyc.size() !== 8) begin
      fails++; $display("FAIL b2b_count got %0d exp 8", log_cyc.size());
    end else begin
      checks++;
      if (log_cyc[0] !== start + 2) begin fails++; $display("FAIL b2b_latency got %0d exp %0d", log_cyc[0], start + 2); end
      for (int k = 1; k < 8; k++) begin
        checks++;
        if (log_cyc[k] - log_cyc[k-1] !== ((k % 2 == 1) ? 1 : 2)) begin
          fails++;
          $display("FAIL b2b_gap beat %0d got %0d exp %0d", k, log_cyc[k] - log_cyc[k-1], (k % 2 == 1) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [73:0] snap;
    logic [73:0] now;
    apply_reset();
    @(negedge aclk);
    load_pkt(1, 6, 64'h300);
    expect_pkt(1, 6, 64'h300);
    for (int i = 0; i < 50 && log_cyc.size() < 2; i++) @(negedge aclk);
    checks++;
    if (log_cyc.size() < 2) begin fails++; $display("FAIL bp_start got %0d beats exp 2", log_cyc.size()); end
    @(posedge aclk); #1;
    sink_ready = 1'b0;
    @(negedge aclk);
    snap = {bus.spawn_in_tid, bus.spawn_in_tdest, bus.spawn_in_tdata, bus.spawn_in_tlast};
    checks++;
    if (bus.spawn_in_tvalid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b exp 1", bus.spawn_in_tvalid); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge aclk);
      now = {bus.spawn_in_tid, bus.spawn_in_tdest, bus.spawn_in_tdata, bus.spawn_in_tlast};
      checks++;
      if (now !== snap || bus.spawn_in_tvalid !== 1'b1) begin
        fails++; $display("FAIL bp_stable got %h exp %h", now, snap);
      end
      checks++;
      if (bus.s_tready !== '0) begin fails++; $display("FAIL bp_s_tready got %b exp 0", bus.s_tready); end
    end
    @(posedge aclk); #1;
    sink_ready = 1'b1;
    wait_drain(50);
    checks++;
    if (log_cyc.size() !== 6) begin fails++; $display("FAIL bp_count got %0d exp 6", log_cyc.size()); end
  endtask

  task automatic test_fairness();
    apply_reset();
    @(negedge aclk);
    load_pkt(0, 2, 64'h400);
    load_pkt(0, 2, 64'h410);
    load_pkt(0, 2, 64'h420);
    load_pkt(3, 2, 64'h700);
    expect_pkt(0, 2, 64'h400);
    expect_pkt(3, 2, 64'h700);
    expect_pkt(0, 2, 64'h410);
    expect_pkt(0, 2, 64'h420);
    wait_drain(80);
    checks++;
    if (log_cyc.size() !== 8) begin
      fails++; $display("FAIL fair_count got %0d exp 8", log_cyc.size());
    end else begin
      checks++;
      if (log_cyc[2] !== log_cyc[1] + 2) begin fails++; $display("FAIL fair_gap got %0d exp %0d", log_cyc[2], log_cyc[1] + 2); end
    end
  endtask

  task automatic test_granted_pause();
    apply_reset();
    @(negedge aclk);
    load_pkt(1, 4, 64'h510);
    expect_pkt(1, 4, 64'h510);
    for (int i = 0; i < 50 && src_head[1] < 2; i++) @(negedge aclk);
    checks++;
    if (src_head[1] < 2) begin fails++; $display("FAIL pause_start got %0d exp 2", src_head[1]); end
    pause[1] = 1'b1;
    load_pkt(0, 2, 64'h600);
    expect_pkt(0, 2, 64'h600);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checks++;
      if (bus.s_tready[0] !== 1'b0) begin fails++; $display("FAIL pause_p0_ready got %b exp 0", bus.s_tready[0]); end
      checks++;
      if (dbg_state !== ST_PASS) begin fails++; $display("FAIL pause_state got %b exp %b", dbg_state, ST_PASS); end
      checks++;
      if (dbg_grant !== 2'd1) begin fails++; $display("FAIL pause_grant got %0d exp 1", dbg_grant); end
    end
    pause[1] = 1'b0;
    wait_drain(60);
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    @(negedge aclk);
    load_pkt(0, 1, 64'h800);
    expect_pkt(0, 1, 64'h800);
    wait_drain(40);
    @(posedge aclk); #1;
    sink_ready = 1'b0;
    @(negedge aclk);
    load_pkt(2, 4, 64'h900);
    for (int i = 0; i < 20 && bus.spawn_in_tvalid !== 1'b1; i++) @(negedge aclk);
    checks++;
    if (bus.spawn_in_tvalid !== 1'b1 || bus.spawn_in_tid !== 4'd2) begin
      fails++; $display("FAIL rmp_inflight got %b/%0d exp 1/2", bus.spawn_in_tvalid, bus.spawn_in_tid);
    end
    @(posedge aclk); #1;
    ps_rst = 1'b1;
    @(negedge aclk);
    clear_sources();
    @(negedge aclk);
    checks++; if (bus.spawn_in_tvalid !== 1'b0) begin fails++; $display("FAIL rmp_tvalid got %b exp 0", bus.spawn_in_tvalid); end
    checks++; if (bus.spawn_in_tdata !== '0) begin fails++; $display("FAIL rmp_tdata got %h exp 0", bus.spawn_in_tdata); end
    checks++; if (bus.spawn_in_tid !== '0) begin fails++; $display("FAIL rmp_tid got %h exp 0", bus.spawn_in_tid); end
    checks++; if (bus.spawn_in_tdest !== '0 || bus.spawn_in_tlast !== 1'b0) begin fails++; $display("FAIL rmp_tdest_tlast got %h/%b exp 0/0", bus.spawn_in_tdest, bus.spawn_in_tlast); end
    checks++; if (bus.s_tready !== '0) begin fails++; $display("FAIL rmp_s_tready got %b exp 0", bus.s_tready); end
    checks++; if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL rmp_state got %b exp %b", dbg_state, ST_IDLE); end
    @(posedge aclk); #1;
    ps_rst     = 1'b0;
    sink_ready = 1'b1;
    @(negedge aclk);
    log_cyc.delete();
    load_pkt(2, 2, 64'hB20);
    load_pkt(0, 2, 64'hB00);
    expect_pkt(0, 2, 64'hB00);
    expect_pkt(2, 2, 64'hB20);
    wait_drain(40);
    checks++;
    if (log_cyc.size() !== 4) begin fails++; $display("FAIL rmp_count got %0d exp 4", log_cyc.size()); end
  endtask

  task automatic test_random_ready();
    int p, q, n1, n2;
    logic [63:0] b1, b2;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      @(negedge aclk);
      p  = $urandom_range(0, NP - 2);
      q  = $urandom_range(p + 1, NP - 1);
      n1 = $urandom_range(1, 5);
      n2 = $urandom_range(1, 5);
      b1 = {32'($urandom), 32'($urandom)};
      b2 = {32'($urandom), 32'($urandom)};
      load_pkt(q, n2, b2);
      load_pkt(p, n1, b1);
      expect_pkt(p, n1, b1);
      expect_pkt(q, n2, b2);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
        @(posedge aclk); #1;
        sink_ready = 1'($urandom_range(0, 1));
      end
      @(posedge aclk); #1;
      sink_ready = 1'b1;
      wait_drain(40);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    ps_rst     = 1'b1;
    sink_ready = 1'b0;
    pause      = '0;
    for (int p = 0; p < NP; p++) src_tail[p] = 0;
    repeat (4) @(posedge aclk);
    #1;
    ps_rst     = 1'b0;
    sink_ready = 1'b1;
    test_reset();
    test_single_request();
    test_back_to_back();
    test_backpressure();
    test_fairness();
    test_granted_pause();
    test_reset_mid_packet();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
